fix_msg_sequencer: RTL

//  Framing controller for the FIX byte stream. Runs the tag/value state machine and decodes tag numbers.

---
 rtl/fix_msg_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fix_msg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fix_msg_sequencer
// Description : FIX byte-stream framing controller. Runs the tag/value state
//               machine, decodes tag numbers, enforces 8=/9=/.../10= order,
//               counts body bytes, accumulates the checksum and reports
//               per-message done/error with resync to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module fix_msg_sequencer #(
    parameter logic [7:0] SOH_CHAR = 8'h7C,
    parameter logic [7:0] SEP_CHAR = 8'h3D,
    parameter int         TAG_W    = 16,
    parameter int         LEN_W    = 16,
    parameter int         MAX_BODY = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             tag_valid_o,
    output logic [TAG_W-1:0] tag_num_o,
    output logic [7:0]       val_byte_o,
    output logic             val_valid_o,
    output logic             field_end_o,
    output logic             msg_start_o,
    output logic             msg_done_o,
    output logic             msg_err_o,
    output logic [2:0]       err_code_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TAG   = 2'd1;
    localparam logic [1:0] c_ST_VALUE = 2'd2;

    localparam logic [2:0] c_ERR_HDR  = 3'd1;
    localparam logic [2:0] c_ERR_TAG  = 3'd2;
    localparam logic [2:0] c_ERR_LEN  = 3'd3;
    localparam logic [2:0] c_ERR_CSUM = 3'd4;
    localparam logic [2:0] c_ERR_OVF  = 3'd5;

    localparam logic [7:0] c_BEGIN_CHAR = 8'h38;

    logic [1:0]       r_state;
    logic [TAG_W-1:0] r_tag_acc;
    logic             r_tag_seen;
    logic [1:0]       r_fidx;
    logic [7:0]       r_csum;
    logic [7:0]       r_csum_snap;
    logic [LEN_W-1:0] r_body_len;
    logic [LEN_W-1:0] r_body_cnt;
    logic [LEN_W-1:0] r_body_snap;
    logic             r_counting;
    logic [9:0]       r_rx_csum;
    logic [1:0]       r_csum_digits;

    logic             r_tag_valid;
    logic [TAG_W-1:0] r_tag_num;
    logic [7:0]       r_val_byte;
    logic             r_val_valid;
    logic             r_field_end;
    logic             r_msg_start;
    logic             r_msg_done;
    logic             r_msg_err;
    logic [2:0]       r_err_code;

    logic             w_is_digit;
    logic [3:0]       w_digit;
    logic [TAG_W+3:0] w_tag_wide;
    logic [TAG_W-1:0] w_tag_next;
    logic [LEN_W+3:0] w_len_wide;
    logic [LEN_W-1:0] w_len_next;
    logic [LEN_W-1:0] w_cnt_next;
    logic [7:0]       w_csum_next;
    logic [9:0]       w_rx_next;
    logic             w_err;
    logic [2:0]       w_err_code;

    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign w_is_digit  = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    assign w_digit     = byte_i[3:0];
    assign w_tag_wide  = {4'd0, r_tag_acc} * (TAG_W+4)'(10) + {TAG_W'(0), w_digit};
    assign w_tag_next  = (|w_tag_wide[TAG_W+3:TAG_W]) ? '1 : w_tag_wide[TAG_W-1:0];
    assign w_len_wide  = {4'd0, r_body_len} * (LEN_W+4)'(10) + {LEN_W'(0), w_digit};
    assign w_len_next  = (|w_len_wide[LEN_W+3:LEN_W]) ? '1 : w_len_wide[LEN_W-1:0];
    assign w_cnt_next  = r_body_cnt + LEN_W'(1);
    assign w_csum_next = r_csum + byte_i;
    assign w_rx_next   = r_rx_csum * 10'd10 + {6'd0, w_digit};

    // Classify the current byte as an abort condition; state errors outrank overflow.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = 3'd0;
        case (r_state)
            c_ST_TAG: begin
                if (!w_is_digit) begin
                    w_err = 1'b1;
                    if (byte_i != SEP_CHAR || !r_tag_seen)
                        w_err_code = c_ERR_TAG;
                    else if (r_fidx == 2'd0 && r_tag_acc != TAG_W'(8))
                        w_err_code = c_ERR_HDR;
                    else if (r_fidx == 2'd1 && r_tag_acc != TAG_W'(9))
                        w_err_code = c_ERR_HDR;
                    else if (r_tag_acc == TAG_W'(10) && r_body_snap != r_body_len)
                        w_err_code = c_ERR_LEN;
                    else
                        w_err = 1'b0;
                end
            end
            c_ST_VALUE: begin
                if (byte_i == SOH_CHAR) begin
                    if (r_tag_num == TAG_W'(10) &&
                        !(r_csum_digits == 2'd3 && r_rx_csum == {2'b00, r_csum_snap})) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_CSUM;
                    end
                end else if (r_tag_num == TAG_W'(9) && !w_is_digit) begin
                    w_err      = 1'b1;
                    w_err_code = c_ERR_HDR;
                end else if (r_tag_num == TAG_W'(10) && (!w_is_digit || r_csum_digits == 2'd3)) begin
                    w_err      = 1'b1;
                    w_err_code = c_ERR_CSUM;
                end
            end
            default: ;
        endcase
        if (!w_err && r_state != c_ST_IDLE && r_counting && w_cnt_next > LEN_W'(MAX_BODY)) begin
            w_err      = 1'b1;
            w_err_code = c_ERR_OVF;
        end
    end

    // Framing state machine with registered pulses and held tag/error values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_tag_acc     <= '0;
            r_tag_seen    <= 1'b0;
            r_fidx        <= 2'd0;
            r_csum        <= 8'd0;
            r_csum_snap   <= 8'd0;
            r_body_len    <= '0;
            r_body_cnt    <= '0;
            r_body_snap   <= '0;
            r_counting    <= 1'b0;
            r_rx_csum     <= 10'd0;
            r_csum_digits <= 2'd0;
            r_tag_valid   <= 1'b0;
            r_tag_num     <= '0;
            r_val_byte    <= 8'd0;
            r_val_valid   <= 1'b0;
            r_field_end   <= 1'b0;
            r_msg_start   <= 1'b0;
            r_msg_done    <= 1'b0;
            r_msg_err     <= 1'b0;
            r_err_code    <= 3'd0;
        end else begin
            r_tag_valid <= 1'b0;
            r_val_valid <= 1'b0;
            r_field_end <= 1'b0;
            r_msg_start <= 1'b0;
            r_msg_done  <= 1'b0;
            r_msg_err   <= 1'b0;
            if (byte_valid_i) begin
                if (r_state == c_ST_IDLE) begin
                    if (byte_i == c_BEGIN_CHAR) begin
                        r_state     <= c_ST_TAG;
                        r_tag_acc   <= TAG_W'(8);
                        r_tag_seen  <= 1'b1;
                        r_fidx      <= 2'd0;
                        r_csum      <= c_BEGIN_CHAR;
                        r_csum_snap <= 8'd0;
                        r_body_len  <= '0;
                        r_body_cnt  <= '0;
                        r_body_snap <= '0;
                        r_counting  <= 1'b0;
                        r_msg_start <= 1'b1;
                    end
                end else if (w_err) begin
                    r_state    <= c_ST_IDLE;
                    r_msg_err  <= 1'b1;
                    r_err_code <= w_err_code;
                end else begin
                    r_csum <= w_csum_next;
                    if (r_counting)
                        r_body_cnt <= w_cnt_next;
                    if (r_state == c_ST_TAG) begin
                        if (w_is_digit) begin
                            r_tag_acc  <= w_tag_next;
                            r_tag_seen <= 1'b1;
                        end else begin
                            r_tag_valid   <= 1'b1;
                            r_tag_num     <= r_tag_acc;
                            r_state       <= c_ST_VALUE;
                            r_rx_csum     <= 10'd0;
                            r_csum_digits <= 2'd0;
                        end
                    end else if (byte_i == SOH_CHAR) begin
                        r_field_end <= 1'b1;
                        r_csum_snap <= w_csum_next;
                        r_body_snap <= r_counting ? w_cnt_next : '0;
                        r_tag_acc   <= '0;
                        r_tag_seen  <= 1'b0;
                        if (r_fidx != 2'd2)
                            r_fidx <= r_fidx + 2'd1;
                        // Body counting starts with the byte after the SOH closing tag 9.
                        if (r_tag_num == TAG_W'(9)) begin
                            r_counting <= 1'b1;
                            r_body_cnt <= '0;
                        end
                        if (r_tag_num == TAG_W'(10)) begin
                            r_msg_done <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_TAG;
                        end
                    end else begin
                        r_val_byte  <= byte_i;
                        r_val_valid <= (byte_i != SEP_CHAR);
                        if (r_tag_num == TAG_W'(9))
                            r_body_len <= w_len_next;
                        if (r_tag_num == TAG_W'(10)) begin
                            r_rx_csum     <= w_rx_next;
                            r_csum_digits <= r_csum_digits + 2'd1;
                        end
                    end
                end
            end
        end
    end

    assign tag_valid_o = r_tag_valid;
    assign tag_num_o   = r_tag_num;
    assign val_byte_o  = r_val_byte;
    assign val_valid_o = r_val_valid;
    assign field_end_o = r_field_end;
    assign msg_start_o = r_msg_start;
    assign msg_done_o  = r_msg_done;
    assign msg_err_o   = r_msg_err;
    assign err_code_o  = r_err_code;

endmodule
`default_nettype wire
